a0_trace_fifo: RTL
==================

// Module: a0_trace_fifo
// PURPOSE
//   Downstream consumer of the CPU's a0 output. Watches a0 every cycle, detects value changes and
//   buffers each change as a {value, timestamp} event in a small FIFO. The display/bench side
//   drains events through a valid/ready handshake, so short a0 pulses (e.g. light patterns that
//   change every cycle) are never lost to a slow reader.
// PARAMETERS
//   DATA_WIDTH  32  width of a0 and out_data
//   DEPTH       8   FIFO entries; power of two, >= 2
//   TS_WIDTH    16  width of the free-running cycle timestamp
// PORTS
//   clk        in   1           clock; all state on rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   a0         in   DATA_WIDTH  CPU a0 register value
//   en         in   1           capture enable
//   out_ready  in   1           consumer accepts head event this cycle
//   clr_ovf    in   1           clears the overflow flag (synchronous)
//   out_valid  out  1           FIFO non-empty; head event presented
//   out_data   out  DATA_WIDTH  a0 value of head event
//   out_ts     out  TS_WIDTH    timestamp of head event
//   count      out  $clog2(DEPTH)+1  entries held
//   overflow   out  1           sticky: a change was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (async assert, sync use after deassert): ts=0, count=0, out_valid=0, out_data=0,
//     out_ts=0, overflow=0, prev_a0=0, first-sample flag armed. Asserting mid-operation discards
//     all buffered events immediately.
//   - ts: increments every cycle regardless of en; wraps 2^TS_WIDTH-1 -> 0.
//   - Detection (en=1 only): event if first-sample flag armed OR a0 != prev_a0. Then prev_a0 <= a0
//     and the flag is cleared. en=0: no detection, prev_a0 and flag hold; changes while disabled
//     collapse into at most one event on re-enable (compared against last captured prev_a0).
//   - Event payload = {a0, ts} as sampled on that edge (ts before its increment).
//   - Push: event and (not full, or pop in same cycle). Full with no pop: event dropped, overflow <= 1.
//   - Pop: out_valid && out_ready. out_valid = (count != 0); no bypass -- a push into an empty
//     FIFO becomes visible on the next cycle (latency: a0 change sampled at edge N -> out_valid
//     high after edge N, i.e. during cycle N+1).
//   - Simultaneous push+pop: count unchanged; when full this accepts the new event (no drop).
//   - out_data/out_ts remain stable while out_valid && !out_ready. When empty they are don't-care
//     after the first event (reset value 0 before it).
//   - Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; full = (count == DEPTH).
//   - overflow: set on a drop, cleared by clr_ovf; set wins if both occur in the same cycle.
// CONFIGURATION
//   A0_TRACE_DROP_CNT_EN
//     defined:   extra output drop_count [7:0]; +1 per dropped event, saturates at 255,
//                reset to 0, cleared by clr_ovf (simultaneous drop+clr_ovf -> value 1).
//     undefined: port absent; only the sticky overflow flag reports drops.
// TESTING
//   1 Reset release, en=1, a0=0 held, out_ready=1 -> exactly one event {0, ts=first sampled
//     cycle}, then out_valid stays 0.
//   2 a0 sequence 0x1,0x3,0x7,0xF on consecutive cycles, out_ready=0 -> count=4 (plus initial
//     event), head values in order, ts strictly consecutive.
//   3 out_ready=0, DEPTH=8, 10 distinct changes -> count=8, overflow=1, first 8 kept;
//     drop_count=2 with A0_TRACE_DROP_CNT_EN; clr_ovf pulse -> overflow=0.
//   4 FIFO full, same cycle out_ready=1 and a0 change -> count stays 8, overflow stays 0,
//     newest event at tail.
//   5 en=0 while a0 goes 0x5->0x6->0x5, then en=1 with prev_a0=0x5 -> no event; repeat ending
//     at 0x6 -> one event {0x6}.
//   6 rst_n low mid-stream with 5 entries -> out_valid=0, count=0 same cycle (async); TS_WIDTH=4
//     run 20 cycles -> event ts wraps 15 -> 0.

Source files
------------

// File: rtl/a0_trace_fifo_if.sv
// Output-side handshake for the a0 trace FIFO: head event {data, ts} with valid/ready.
interface a0_trace_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TS_WIDTH-1:0]   out_ts;

  modport master (output out_valid, output out_data, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ts, output out_ready);
endinterface

// File: rtl/a0_trace_fifo.sv
// Captures changes on a0 as {value, timestamp} events in a small FIFO drained by valid/ready.
// Optional feature macro A0_TRACE_DROP_CNT_EN adds a saturating drop_count_o output.
module a0_trace_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  a0_i,
  input  logic                   en_i,
  input  logic                   clr_ovf_i,
  a0_trace_fifo_if.master        out_if,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
`ifdef A0_TRACE_DROP_CNT_EN
  ,
  output logic [7:0]             drop_count_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem_q   [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  armed_q;
  logic                  overflow_q, overflow_d;
  logic                  evt, full, pop, push, drop;

  always_comb begin
    evt  = en_i && (armed_q || (a0_i != prev_q));
    full = (count_q == CW'(DEPTH));
    pop  = (count_q != '0) && out_if.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
    push = evt && (!full || pop);
    drop = evt && full && !pop;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      armed_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_WIDTH'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (evt) begin
        prev_q  <= a0_i;
        armed_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is cleared so the head reads 0 until the first event lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        ts_mem_q[i]   <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= a0_i;
      ts_mem_q[wr_ptr_q]   <= ts_q;
    end
  end

  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = data_mem_q[rd_ptr_q];
  assign out_if.out_ts    = ts_mem_q[rd_ptr_q];
  assign count_o          = count_q;
  assign overflow_o       = overflow_q;

`ifdef A0_TRACE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf_i) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif
endmodule
